// File: rtl/imem_loader.sv
// Byte-stream loader: parses {N, N words, XOR checksum} and writes words into an instruction memory.
// One-cycle write latency after each HI byte; the stream is stalled through in_ready outside the load states.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_W_LO, S_W_HI, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_len;
  logic [7:0]          r_lo;
  logic [7:0]          r_xor;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;

  logic                w_active;
  logic                w_accept;
  logic                w_start;
  logic [15:0]         w_n;
  logic                w_len_bad;
  logic                w_last;

  always_comb begin
    w_active  = 1'b0;
    w_start   = 1'b0;
    unique case (r_state)
      S_HDR_LO, S_HDR_HI, S_W_LO, S_W_HI, S_CSUM: w_active = 1'b1;
      default:                                    w_start  = start;
    endcase
    w_accept  = in_valid && w_active;
    w_n       = {in_data, r_len[7:0]};
    w_len_bad = (w_n == 16'd0) || ({1'b0, w_n} > DEPTH);
    // Last word is the one whose index is N-1; the index never advances past it.
    w_last    = ((17'(r_idx) + 17'd1) == {1'b0, r_len});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_start) w_next = S_HDR_LO;
      S_HDR_LO: if (w_accept) w_next = S_HDR_HI;
      S_HDR_HI: if (w_accept) w_next = w_len_bad ? S_ERR : S_W_LO;
      S_W_LO:   if (w_accept) w_next = S_W_HI;
      S_W_HI:   if (w_accept) w_next = w_last ? S_CSUM : S_W_LO;
      S_CSUM:   if (w_accept) w_next = (in_data == r_xor) ? S_DONE : S_ERR;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len     <= '0;
      r_lo      <= '0;
      r_xor     <= '0;
      r_idx     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_start) begin
        r_idx <= '0;
        r_xor <= '0;
      end else if (w_accept) begin
        if (r_state != S_CSUM) r_xor <= r_xor ^ in_data;
        unique case (r_state)
          S_HDR_LO: r_len[7:0]  <= in_data;
          S_HDR_HI: r_len[15:8] <= in_data;
          S_W_LO:   r_lo        <= in_data;
          S_W_HI: begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_idx;
            r_wr_data <= {in_data[DATA_W-9:0], r_lo};
            if (!w_last) r_idx <= r_idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready = w_active;
  assign busy     = w_active;
  assign done     = (r_state == S_DONE);
  assign err      = (r_state == S_ERR);
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: builds byte streams from word lists and scores the write sequence.
module tb_imem_loader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 9;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  int  nchecks = 0;
  int  nerrs   = 0;
  wr_t got_q[$];
  bit  gaps_on = 1'b0;

  bit                prev_vld = 1'b0;
  logic [ADDR_W-1:0] prev_a;
  logic [DATA_W-1:0] prev_d;

  // Write capture plus cycle-level invariants: outputs hold between writes, done/err exclusive.
  always @(negedge clk) begin
    if (reset) begin
      prev_vld = 1'b0;
    end else begin
      if (wr_en) got_q.push_back({wr_addr, wr_data});
      else if (prev_vld) begin
        nchecks++;
        if (wr_addr !== prev_a || wr_data !== prev_d) begin
          nerrs++;
          $display("FAIL wr_hold: got addr %0h data %0h, expected %0h %0h", wr_addr, wr_data, prev_a, prev_d);
        end
      end
      nchecks++;
      if (done && err) begin
        nerrs++;
        $display("FAIL done_err_excl: done=%0b err=%0b both high", done, err);
      end
      prev_vld = 1'b1;
      prev_a   = wr_addr;
      prev_d   = wr_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    if (gaps_on) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      nchecks++;
      nerrs++;
      $display("FAIL send_timeout: in_ready=%0b, expected 1 within 20 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Reference: stream = header, LO/HI per word, XOR of everything; write i = (i, word truncated to DATA_W).
  task automatic run_load(input string name, input logic [15:0] n, input logic [15:0] words[$],
                          input bit bad_csum, input int mid_at);
    logic [7:0] bytes[$];
    wr_t        exp_q[$];
    logic [7:0] x;
    bit         len_bad;
    int         k;
    len_bad = (n == 0) || (int'(n) > DEPTH);
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    if (!len_bad) begin
      for (int i = 0; i < int'(n); i++) begin
        bytes.push_back(words[i][7:0]);
        bytes.push_back(words[i][15:8]);
        exp_q.push_back({ADDR_W'(i), DATA_W'(words[i])});
      end
      x = 8'h00;
      foreach (bytes[i]) x = x ^ bytes[i];
      if (bad_csum) x = x ^ 8'($urandom_range(1, 255));
      bytes.push_back(x);
    end
    got_q.delete();
    pulse_start();
    foreach (bytes[i]) begin
      if (i == mid_at) pulse_start();
      send_byte(bytes[i]);
    end
    k = 0;
    while (!(done || err) && k < 40) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    nchecks++;
    if (done !== !(len_bad || bad_csum)) begin
      nerrs++;
      $display("FAIL %s done: got %0b, expected %0b", name, done, !(len_bad || bad_csum));
    end
    nchecks++;
    if (err !== (len_bad || bad_csum)) begin
      nerrs++;
      $display("FAIL %s err: got %0b, expected %0b", name, err, (len_bad || bad_csum));
    end
    nchecks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      nerrs++;
      $display("FAIL %s idle_after: busy=%0b in_ready=%0b, expected 0 0", name, busy, in_ready);
    end
    nchecks++;
    if (got_q.size() != exp_q.size()) begin
      nerrs++;
      $display("FAIL %s write_count: got %0d, expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      nchecks++;
      if (got_q[i] !== exp_q[i]) begin
        nerrs++;
        $display("FAIL %s write[%0d]: got (%0h,%0h), expected (%0h,%0h)", name, i,
                 got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
  endtask

  task automatic rand_words(input int n, output logic [15:0] w[$]);
    w.delete();
    for (int i = 0; i < n; i++) w.push_back(16'($urandom));
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    nchecks++;
    if ({in_ready, wr_en, busy, done, err} !== 5'b0) begin
      nerrs++;
      $display("FAIL reset_flags: got %b, expected 00000", {in_ready, wr_en, busy, done, err});
    end
    nchecks++;
    if (wr_addr !== '0 || wr_data !== '0) begin
      nerrs++;
      $display("FAIL reset_bus: got addr %0h data %0h, expected 0 0", wr_addr, wr_data);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    nchecks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      nerrs++;
      $display("FAIL reset_wait_start: busy=%0b in_ready=%0b, expected 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [15:0] w[$];
    w = '{16'h0111, 16'h0022, 16'h0133};
    run_load("basic", 16'd3, w, 1'b0, -1);
  endtask

  task automatic test_len_bounds();
    logic [15:0] w[$];
    w.delete();
    run_load("len_zero", 16'd0, w, 1'b0, -1);
    run_load("len_1025", 16'd1025, w, 1'b0, -1);
    rand_words(1024, w);
    run_load("len_1024", 16'd1024, w, 1'b0, -1);
    nchecks++;
    if (got_q.size() == 0 || got_q[got_q.size()-1].a !== ADDR_W'(1023)) begin
      nerrs++;
      $display("FAIL len_1024_last_addr: got %0d writes, expected last addr 1023", got_q.size());
    end
  endtask

  task automatic test_bad_csum();
    logic [15:0] w[$];
    int n;
    n = $urandom_range(1, 8);
    rand_words(n, w);
    run_load("bad_csum", 16'(n), w, 1'b1, -1);
  endtask

  task automatic test_gaps_mid_start();
    logic [15:0] w[$];
    int n;
    gaps_on = 1'b1;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(2, 12);
      rand_words(n, w);
      run_load("gaps_mid_start", 16'(n), w, 1'b0, $urandom_range(1, 2 * n));
    end
    gaps_on = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[$];
    int n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 20);
      rand_words(n, w);
      run_load("back_to_back", 16'(n), w, 1'b0, -1);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] w[$];
    got_q.delete();
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h44);
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h00);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    nchecks++;
    if ({in_ready, wr_en, busy, done, err} !== 5'b0) begin
      nerrs++;
      $display("FAIL async_reset_flags: got %b, expected 00000", {in_ready, wr_en, busy, done, err});
    end
    nchecks++;
    if (wr_addr !== '0 || wr_data !== '0) begin
      nerrs++;
      $display("FAIL async_reset_bus: got addr %0h data %0h, expected 0 0", wr_addr, wr_data);
    end
    nchecks++;
    if (got_q.size() != 2) begin
      nerrs++;
      $display("FAIL reset_prior_writes: got %0d, expected 2", got_q.size());
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    nchecks++;
    if (got_q.size() != 2 || busy !== 1'b0) begin
      nerrs++;
      $display("FAIL reset_abandon: writes=%0d busy=%0b, expected 2 0", got_q.size(), busy);
    end
    rand_words(3, w);
    run_load("after_reset", 16'd3, w, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_bounds();
    test_bad_csum();
    test_gaps_mid_start();
    test_back_to_back();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
